mem_loader: RTL and testbench
=============================

// Module: mem_loader
// PURPOSE
//  Host-side load controller in front of the mem_mesh write ports. Accepts a
//  header word plus a stream of data words on a valid/ready interface. Writes
//  the data at consecutive addresses through one target core's write lane,
//  using the header's wspread, so a single load can fill one block or all of them.
//  While a load is in progress, cpu_stall is high and every CPU write is masked.
//  When idle, CPU writes pass straight through to mem_mesh.
// PARAMETERS
//  CORES        8   number of cores / write lanes
//  DATA_WIDTH   16  word size; must be >= ADDR_WIDTH+SPREAD_WIDTH+CORE_BITS
//  ADDR_WIDTH   8   write address width (DEPTH = 2**ADDR_WIDTH)
//  SPREAD_WIDTH 3   wspread field width
//  CORE_BITS    3   target-core field width, clog2(CORES)
// PORTS
//  clk          in   1                    clock
//  rst_n        in   1                    reset: asynchronous, active-low
//  host_valid   in   1                    host word valid
//  host_ready   out  1                    loader accepts word this cycle
//  host_data    in   DATA_WIDTH           header or data word
//  host_last    in   1                    marks the final word of a load
//  cpu_we       in   CORES                CPU write enables
//  cpu_waddr    in   CORES*ADDR_WIDTH     CPU write addresses
//  cpu_wspread  in   CORES*SPREAD_WIDTH   CPU write spreads
//  cpu_wdata    in   CORES*DATA_WIDTH     CPU write data
//  mem_we       out  CORES                to mem_mesh we
//  mem_waddr    out  CORES*ADDR_WIDTH     to mem_mesh waddr
//  mem_wspread  out  CORES*SPREAD_WIDTH   to mem_mesh wspread
//  mem_wdata    out  CORES*DATA_WIDTH     to mem_mesh wdata
//  cpu_stall    out  1                    registered; high while a load is active
//  load_done    out  1                    registered; one-cycle pulse at end of a load
// BEHAVIOUR
//  Reset: state=IDLE. cpu_stall, load_done and all loader write registers are 0.
//   Reset applied mid-load aborts the load; the remaining words are not written.
//  Header layout: [ADDR_WIDTH-1:0] start address; next SPREAD_WIDTH bits wspread;
//   next CORE_BITS bits target core. The remaining upper bits are ignored.
//  A beat transfers on a cycle where host_valid & host_ready are both high.
//  States:
//  - IDLE: host_ready=1. mem_* = cpu_* (combinational passthrough).
//    On a header beat: latch addr, spread and core; set cpu_stall.
//    Go to DATA, or to DONE if host_last=1 (zero-length load, no write).
//  - DATA: host_ready=1. mem_* is driven by the loader for the whole state.
//    A data beat registers a write, presented one cycle later on lane [core]:
//    mem_we[core]=1, waddr=cur, wspread=hdr, wdata=host_data.
//    All other lanes have we=0. Each beat does cur <= cur+1, mod 2**ADDR_WIDTH.
//    A cycle with no beat presents no write (we=0).
//    A beat with host_last=1 goes to DONE.
//  - DONE: host_ready=0; presents the final pending write; load_done=1.
//    Next cycle: IDLE, cpu_stall=0.
//  Latency: a data beat reaches mem_mesh exactly 1 cycle after acceptance.
//  While stalled, all cpu_we are masked and CPU writes are dropped.
//   The CPUs must hold off on cpu_stall.
//  Target core >= CORES (non power-of-two CORES): beats are accepted, no write.
//  Back-to-back loads are allowed. A header accepted in the IDLE cycle
//   directly after DONE gives one passthrough cycle between the two loads.
// CONFIGURATION
//  MEM_LOADER_CSUM_EN defined:
//  - Adds output load_csum [DATA_WIDTH]: XOR of all data words in the last load.
//  - Cleared on each header beat and on reset; holds its value from DONE onward.
//  Undefined: no load_csum port and no checksum logic.
// TESTING
//  1. Header 0x0810 (addr 0x10, spread 0, core 1) + 3 words A,B,C (last on C):
//     mem_we=0x02 at addr 0x10/0x11/0x12, one cycle after each beat;
//     load_done pulses once; cpu_stall drops the cycle after DONE.
//  2. Header addr 0xFE, spread 4, core 0 + 3 words:
//     addresses 0xFE, 0xFF, 0x00 (wrap); wspread=4 on lane 0 only.
//  3. cpu_we=0xFF held through a load: no CPU write reaches mem_we while
//     cpu_stall=1; passthrough resumes in IDLE.
//  4. Header with host_last=1: no mem write; load_done pulses; back in IDLE in 2 cycles.
//  5. host_valid gaps between data beats: no spurious writes; addresses stay contiguous.
//  6. rst_n low mid-DATA: all outputs 0 immediately; after release, a new load works.
//  (CSUM) words 0x1234, 0x00FF -> load_csum=0x12CB after DONE.

Source files
------------

// File: rtl/mem_loader.sv
//------------------------------------------------------------------------------
// mem_loader
//   Host-side load controller in front of the mem_mesh write ports.
//   A load is one header word followed by data words on a valid/ready stream.
//   The header selects a start address, a wspread value and a target core. Each
//   data word is written at the next consecutive address through that core's
//   write lane. A load holds the CPUs off with cpu_stall and masks their writes.
//   When no load is running, CPU writes pass straight through to mem_mesh.
//
//   Header word layout (LSB first):
//     [ADDR_WIDTH-1:0]   start address
//     next SPREAD_WIDTH  wspread
//     next CORE_BITS     target core
//     any upper bits are ignored
//
//   Ports
//     clk, rst_n         clock, asynchronous active-low reset
//     host_valid/ready   host word handshake (beat = valid & ready)
//     host_data          header or data word
//     host_last          final word of a load
//     cpu_we/waddr/      CPU write lanes (CORES lanes, packed lane-major)
//       wspread/wdata
//     mem_we/waddr/      write lanes toward mem_mesh
//       wspread/wdata
//     cpu_stall          registered, high while a load is active
//     load_done          registered, one-cycle pulse in the last load cycle
//     load_csum          (MEM_LOADER_CSUM_EN only) XOR of the last load's data
//
//   Configuration macro: MEM_LOADER_CSUM_EN adds the load_csum output.
//------------------------------------------------------------------------------
module mem_loader #(
   parameter int CORES        = 8,
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 8,
   parameter int SPREAD_WIDTH = 3,
   parameter int CORE_BITS    = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           host_valid,
   output logic                           host_ready,
   input  logic [DATA_WIDTH-1:0]          host_data,
   input  logic                           host_last,
   input  logic [CORES-1:0]               cpu_we,
   input  logic [CORES*ADDR_WIDTH-1:0]    cpu_waddr,
   input  logic [CORES*SPREAD_WIDTH-1:0]  cpu_wspread,
   input  logic [CORES*DATA_WIDTH-1:0]    cpu_wdata,
   output logic [CORES-1:0]               mem_we,
   output logic [CORES*ADDR_WIDTH-1:0]    mem_waddr,
   output logic [CORES*SPREAD_WIDTH-1:0]  mem_wspread,
   output logic [CORES*DATA_WIDTH-1:0]    mem_wdata,
   output logic                           cpu_stall,
   output logic                           load_done
`ifdef MEM_LOADER_CSUM_EN
   ,
   output logic [DATA_WIDTH-1:0]          load_csum
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                   r_state;
   state_t                   w_next;

   logic                     w_beat;
   logic                     w_core_ok;

   logic [ADDR_WIDTH-1:0]    r_addr;     // address of the next data word
   logic [SPREAD_WIDTH-1:0]  r_spread;   // wspread from the header
   logic [CORE_BITS-1:0]     r_core;     // target lane from the header
   logic                     r_we;       // a registered write is presented this cycle
   logic [ADDR_WIDTH-1:0]    r_waddr;
   logic [DATA_WIDTH-1:0]    r_wdata;
   logic                     r_stall;
   logic                     r_done;

   assign w_beat    = host_valid & host_ready;
   // A header naming a core beyond CORES still consumes its words, but
   // no lane is ever enabled for it.
   assign w_core_ok = (32'(r_core) < CORES);

   assign cpu_stall = r_stall;
   assign load_done = r_done;

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would infer a latch.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_beat) w_next = host_last ? S_DONE : S_DATA;
         S_DATA: if (w_beat && host_last) w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // Load datapath registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr   <= '0;
         r_spread <= '0;
         r_core   <= '0;
         r_we     <= 1'b0;
         r_waddr  <= '0;
         r_wdata  <= '0;
         r_stall  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         // Stall covers every cycle spent outside IDLE, including DONE.
         r_stall <= (w_next != S_IDLE);
         r_done  <= (w_next == S_DONE);
         r_we    <= 1'b0;
         if (w_beat) begin
            if (r_state == S_IDLE) begin
               r_addr   <= host_data[ADDR_WIDTH-1:0];
               r_spread <= host_data[ADDR_WIDTH +: SPREAD_WIDTH];
               r_core   <= host_data[ADDR_WIDTH+SPREAD_WIDTH +: CORE_BITS];
            end else if (r_state == S_DATA) begin
               r_we    <= 1'b1;
               r_waddr <= r_addr;
               r_wdata <= host_data;
               // Wraps naturally at 2**ADDR_WIDTH.
               r_addr  <= r_addr + ADDR_WIDTH'(1);
            end
         end
      end
   end

`ifdef MEM_LOADER_CSUM_EN
   logic [DATA_WIDTH-1:0] r_csum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_csum <= '0;
      end else if (w_beat) begin
         if (r_state == S_IDLE)      r_csum <= '0;
         else if (r_state == S_DATA) r_csum <= r_csum ^ host_data;
      end
   end

   assign load_csum = r_csum;
`endif

   //---------------------------------------------------------------------------
   // Output logic: CPU passthrough in IDLE, loader-owned lanes otherwise
   //---------------------------------------------------------------------------
   always_comb begin
      host_ready  = 1'b1;
      mem_we      = '0;
      mem_waddr   = '0;
      mem_wspread = '0;
      mem_wdata   = '0;
      if (r_state == S_IDLE) begin
         mem_we      = cpu_we;
         mem_waddr   = cpu_waddr;
         mem_wspread = cpu_wspread;
         mem_wdata   = cpu_wdata;
      end else begin
         // CPU lanes are fully masked here; only the pending loader write shows.
         host_ready = (r_state == S_DATA);
         if (r_we && w_core_ok) begin
            mem_we[r_core]                                    = 1'b1;
            mem_waddr[32'(r_core)*ADDR_WIDTH +: ADDR_WIDTH]     = r_waddr;
            mem_wspread[32'(r_core)*SPREAD_WIDTH +: SPREAD_WIDTH] = r_spread;
            mem_wdata[32'(r_core)*DATA_WIDTH +: DATA_WIDTH]     = r_wdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
//------------------------------------------------------------------------------
// tb_mem_loader
//   Directed, table-driven bench for mem_loader. Each table row is one clock
//   cycle: inputs applied after the falling edge, outputs compared 1 ns later.
//   CPU lanes carry a fixed pattern (addr 0x40+i, spread i, data 0xC000+i) so
//   passthrough rows can check a lane's address/spread/data fields.
//------------------------------------------------------------------------------
module tb_mem_loader;

   localparam int CORES = 8;
   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int SW    = 3;
   localparam int CB    = 3;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 host_valid;
   logic                 host_ready;
   logic [DW-1:0]        host_data;
   logic                 host_last;
   logic [CORES-1:0]     cpu_we;
   logic [CORES*AW-1:0]  cpu_waddr;
   logic [CORES*SW-1:0]  cpu_wspread;
   logic [CORES*DW-1:0]  cpu_wdata;
   logic [CORES-1:0]     mem_we;
   logic [CORES*AW-1:0]  mem_waddr;
   logic [CORES*SW-1:0]  mem_wspread;
   logic [CORES*DW-1:0]  mem_wdata;
   logic                 cpu_stall;
   logic                 load_done;
`ifdef MEM_LOADER_CSUM_EN
   logic [DW-1:0]        load_csum;
`endif

   always #5 clk = ~clk;

   mem_loader #(
      .CORES(CORES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .SPREAD_WIDTH(SW), .CORE_BITS(CB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .host_valid (host_valid),
      .host_ready (host_ready),
      .host_data  (host_data),
      .host_last  (host_last),
      .cpu_we     (cpu_we),
      .cpu_waddr  (cpu_waddr),
      .cpu_wspread(cpu_wspread),
      .cpu_wdata  (cpu_wdata),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr),
      .mem_wspread(mem_wspread),
      .mem_wdata  (mem_wdata),
      .cpu_stall  (cpu_stall),
      .load_done  (load_done)
`ifdef MEM_LOADER_CSUM_EN
      ,
      .load_csum  (load_csum)
`endif
   );

   typedef struct {
      logic        v;
      logic [15:0] d;
      logic        l;
      logic [7:0]  cwe;
      logic        e_rdy;
      logic [7:0]  e_we;
      int          e_lane;   // -1: lane fields not compared
      logic [7:0]  e_addr;
      logic [2:0]  e_spr;
      logic [15:0] e_wdata;
      logic        e_stall;
      logic        e_done;
   } vec_t;

   vec_t vecs[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic add(input logic v, input logic [15:0] d, input logic l, input logic [7:0] cwe,
                      input logic rdy, input logic [7:0] we, input int lane, input logic [7:0] a,
                      input logic [2:0] s, input logic [15:0] wd, input logic st, input logic dn);
      vec_t x;
      x.v = v; x.d = d; x.l = l; x.cwe = cwe;
      x.e_rdy = rdy; x.e_we = we; x.e_lane = lane; x.e_addr = a;
      x.e_spr = s; x.e_wdata = wd; x.e_stall = st; x.e_done = dn;
      vecs.push_back(x);
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic l, input logic [7:0] cwe);
      @(negedge clk);
      host_valid = v;
      host_data  = d;
      host_last  = l;
      cpu_we     = cwe;
      #1;
   endtask

   task automatic check_lane(input string tag, input int lane, input logic [7:0] a,
                             input logic [2:0] s, input logic [15:0] wd);
      check({tag, " waddr"},   32'(mem_waddr[lane*AW +: AW]),   32'(a));
      check({tag, " wspread"}, 32'(mem_wspread[lane*SW +: SW]), 32'(s));
      check({tag, " wdata"},   32'(mem_wdata[lane*DW +: DW]),   32'(wd));
   endtask

   initial begin
      string tag;
      rst_n      = 1'b0;
      host_valid = 1'b0;
      host_data  = '0;
      host_last  = 1'b0;
      cpu_we     = '0;
      for (int i = 0; i < CORES; i++) begin
         cpu_waddr[i*AW +: AW]   = 8'(8'h40 + i);
         cpu_wspread[i*SW +: SW] = 3'(i);
         cpu_wdata[i*DW +: DW]   = 16'(16'hC000 + i);
      end

      // Reset state
      #12;
      check("reset stall", 32'(cpu_stall), 32'd0);
      check("reset done",  32'(load_done), 32'd0);
      check("reset we",    32'(mem_we),    32'd0);
      check("reset ready", 32'(host_ready), 32'd1);
`ifdef MEM_LOADER_CSUM_EN
      check("reset csum",  32'(load_csum), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      //   v  data     l  cwe    rdy we     lane a      s     wdata     st dn
      // 1: addr 0x10, spread 0, core 1, three words
      add(1, 16'h0810, 0, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 0, 0);
      add(1, 16'hAAAA, 0, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 1, 0);
      add(1, 16'hBBBB, 0, 8'h00, 1, 8'h02,  1, 8'h10, 3'd0, 16'hAAAA, 1, 0);
      add(1, 16'hCCCC, 1, 8'h00, 1, 8'h02,  1, 8'h11, 3'd0, 16'hBBBB, 1, 0);
      add(0, 16'h0000, 0, 8'h00, 0, 8'h02,  1, 8'h12, 3'd0, 16'hCCCC, 1, 1);
      add(0, 16'h0000, 0, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 0, 0);
      // 2: addr 0xFE, spread 4, core 0 -> address wrap
      add(1, 16'h04FE, 0, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 0, 0);
      add(1, 16'h1111, 0, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 1, 0);
      add(1, 16'h2222, 0, 8'h00, 1, 8'h01,  0, 8'hFE, 3'd4, 16'h1111, 1, 0);
      add(1, 16'h3333, 1, 8'h00, 1, 8'h01,  0, 8'hFF, 3'd4, 16'h2222, 1, 0);
      add(0, 16'h0000, 0, 8'h00, 0, 8'h01,  0, 8'h00, 3'd4, 16'h3333, 1, 1);
      add(0, 16'h0000, 0, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 0, 0);
      // 3: cpu_we=0xFF held; addr 0x20, spread 1, core 2
      add(1, 16'h1120, 0, 8'hFF, 1, 8'hFF,  3, 8'h43, 3'd3, 16'hC003, 0, 0);
      add(1, 16'h5555, 0, 8'hFF, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 1, 0);
      add(1, 16'h6666, 1, 8'hFF, 1, 8'h04,  2, 8'h20, 3'd1, 16'h5555, 1, 0);
      add(0, 16'h0000, 0, 8'hFF, 0, 8'h04,  2, 8'h21, 3'd1, 16'h6666, 1, 1);
      add(0, 16'h0000, 0, 8'hFF, 1, 8'hFF,  3, 8'h43, 3'd3, 16'hC003, 0, 0);
      // 4: zero-length load (header carries last)
      add(1, 16'h0830, 1, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 0, 0);
      add(0, 16'h0000, 0, 8'h00, 0, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 1, 1);
      add(0, 16'h0000, 0, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 0, 0);
      // 5: valid gaps; addr 0x80, spread 7, core 7
      add(1, 16'h3F80, 0, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 0, 0);
      add(0, 16'h0000, 0, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 1, 0);
      add(1, 16'h7001, 0, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 1, 0);
      add(0, 16'hDEAD, 0, 8'h00, 1, 8'h80,  7, 8'h80, 3'd7, 16'h7001, 1, 0);
      add(0, 16'hDEAD, 1, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 1, 0);
      add(1, 16'h7002, 1, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 1, 0);
      add(0, 16'h0000, 0, 8'h00, 0, 8'h80,  7, 8'h81, 3'd7, 16'h7002, 1, 1);
      // back-to-back: header in the IDLE cycle right after DONE (core 3, addr 0x05)
      add(1, 16'h1805, 0, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 0, 0);
      add(1, 16'h0BEE, 1, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 1, 0);
      add(0, 16'h0000, 0, 8'h00, 0, 8'h08,  3, 8'h05, 3'd0, 16'h0BEE, 1, 1);
      add(0, 16'h0000, 0, 8'h00, 1, 8'h00, -1, 8'h00, 3'd0, 16'h0000, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].cwe);
         tag = $sformatf("row%0d", i);
         check({tag, " ready"}, 32'(host_ready), 32'(vecs[i].e_rdy));
         check({tag, " we"},    32'(mem_we),     32'(vecs[i].e_we));
         check({tag, " stall"}, 32'(cpu_stall),  32'(vecs[i].e_stall));
         check({tag, " done"},  32'(load_done),  32'(vecs[i].e_done));
         if (vecs[i].e_lane >= 0)
            check_lane(tag, vecs[i].e_lane, vecs[i].e_addr, vecs[i].e_spr, vecs[i].e_wdata);
      end

      // 6: reset mid-DATA aborts the load, then a fresh load works
      drive(1, 16'h0810, 0, 8'h00);
      drive(1, 16'h7777, 0, 8'h00);
      drive(0, 16'h0000, 0, 8'h00);
      check("pre-reset we", 32'(mem_we), 32'h02);
      rst_n = 1'b0;
      #1;
      check("midreset stall", 32'(cpu_stall), 32'd0);
      check("midreset done",  32'(load_done), 32'd0);
      check("midreset we",    32'(mem_we),    32'd0);
      check("midreset ready", 32'(host_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 16'h0900, 0, 8'h00);
      drive(1, 16'h4242, 1, 8'h00);
      check("postreset stall", 32'(cpu_stall), 32'd1);
      drive(0, 16'h0000, 0, 8'h00);
      check("postreset we",   32'(mem_we),    32'h02);
      check("postreset done", 32'(load_done), 32'd1);
      check_lane("postreset", 1, 8'h00, 3'd1, 16'h4242);
      drive(0, 16'h0000, 0, 8'h00);
      check("postreset idle stall", 32'(cpu_stall), 32'd0);

`ifdef MEM_LOADER_CSUM_EN
      drive(1, 16'h0000, 0, 8'h00);
      drive(1, 16'h1234, 0, 8'h00);
      drive(1, 16'h00FF, 1, 8'h00);
      drive(0, 16'h0000, 0, 8'h00);
      check("csum done", 32'(load_csum), 32'h12CB);
      drive(0, 16'h0000, 0, 8'h00);
      check("csum hold", 32'(load_csum), 32'h12CB);
      drive(1, 16'h0000, 1, 8'h00);
      drive(0, 16'h0000, 0, 8'h00);
      check("csum cleared", 32'(load_csum), 32'h0000);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
